// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares a single-port 64-word data memory between instruction fetch (I port,
// read-only) and the load/store unit (D port, read/write). Every access is a
// three-state transaction: IDLE (arbitrate and latch), ACCESS (drive the
// memory for exactly one cycle), RESP (one-cycle ack to the winner).
//
// The D port has fixed priority. A wait counter tracks consecutive D grants
// taken while a fetch is pending. Once it reaches MAX_WAIT, the next grant
// goes to I.
//
// Parameters
//   MAX_WAIT    consecutive D grants tolerated while i_req is pending (1..15)
//   ADDR_LIMIT  first byte address outside the memory; accesses at or above
//               it complete with err=1 and never touch the memory
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   i_req, i_addr                fetch request, held until i_ack
//   i_ack, i_rdata               fetch done pulse, fetched word
//   d_req, d_we, d_addr, d_wdata load/store request, held until d_ack
//   d_ack, d_rdata               load/store done pulse, loaded word
//   err                          qualifies the ack: access was out of range
//   busy                         high in ACCESS and RESP
//   MemRead, MemWrite            memory strobes (ACCESS only, never both)
//   MemAddress, WriteData        memory address / write data (0 outside ACCESS)
//   ReadData                     memory combinational read data

module mem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        range_err_q;
  logic [3:0]  wait_cnt_q;

  logic        grant_d;
  logic        grant_i;

  // Winner selection; only acted on in IDLE. D loses its priority only when
  // a fetch has already been passed over MAX_WAIT times in a row.
  always_comb begin
    grant_d = d_req && !(i_req && (wait_cnt_q == MAX_WAIT_C));
    grant_i = i_req && !grant_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore). Reset forces IDLE asynchronously, so the strobes
  // drop the moment rst_n falls and an interrupted store is never committed.
  // ---------------------------------------------------------------------------
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddress = '0;
    WriteData  = '0;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    err        = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ACCESS: begin
        busy = 1'b1;
        if (!range_err_q) begin
          MemRead    = !we_q;
          MemWrite   = we_q;
          MemAddress = addr_q;
          WriteData  = we_q ? wdata_q : '0;
        end
      end
      RESP: begin
        busy  = 1'b1;
        i_ack = (owner_q == OWNER_I);
        d_ack = (owner_q == OWNER_D);
        err   = range_err_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and starvation counter, updated only at the IDLE exit edge
  // (or every IDLE cycle for the counter clear).
  // ---------------------------------------------------------------------------
  // NOTE: the latched request fields are reset even though they are only
  // observed after a grant; this keeps the bus outputs deterministic and
  // costs nothing since these are a handful of flops, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWNER_I;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      range_err_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else if (state_q == IDLE) begin
      if (grant_d) begin
        owner_q     <= OWNER_D;
        addr_q      <= d_addr;
        we_q        <= d_we;
        wdata_q     <= d_wdata;
        range_err_q <= (d_addr >= ADDR_LIMIT);
        // Count only grants that bypass a waiting fetch; a D grant with no
        // fetch pending is an IDLE cycle with i_req=0 and clears the count.
        if (!i_req) begin
          wait_cnt_q <= '0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
        end
      end else if (grant_i) begin
        owner_q     <= OWNER_I;
        addr_q      <= i_addr;
        we_q        <= 1'b0;
        wdata_q     <= '0;
        range_err_q <= (i_addr >= ADDR_LIMIT);
        wait_cnt_q  <= '0;
      end else begin
        wait_cnt_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data capture at the ACCESS exit edge. Each port keeps its last read
  // value until its next read; stores leave d_rdata untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (owner_q == OWNER_I) begin
        i_rdata <= range_err_q ? '0 : ReadData;
      end else begin
        d_rdata <= range_err_q ? '0 : ReadData;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-port drivers present queued transactions
// back-to-back, a reference model predicts the service order and results
// from the arbitration rules, and a monitor compares every ack against the
// scoreboard.

module tb_mem_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam logic [31:0] LIMIT    = 32'h100;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        busy;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .err        (err),
    .busy       (busy),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemAddress (MemAddress),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory attached to the DUT: combinational read, write on edge.
  logic [31:0] mem [64] = '{default: 32'h0};
  assign ReadData = mem[MemAddress[7:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[MemAddress[7:2]] <= WriteData;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
    logic [1:0]  strobe;   // {read, write} seen during ACCESS
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          cyc;
  } exp_t;

  txn_t iq[$];
  txn_t dq[$];
  exp_t sb[$];

  // Reference state
  logic [31:0] ref_mem [64];
  logic [31:0] last_i;
  logic [31:0] last_d;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no ack within cycle budget (cycle %0d)", name, cyc);
  endtask

  function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    return t;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, 255));
    return LIMIT + ($urandom() & 32'h0000_FFFF);
  endfunction

  // Reference model: with both ports kept continuously pending, each grant
  // decision sees exactly the ports whose queues are non-empty. Results come
  // out in service order, one every three cycles.
  function automatic void predict(input int start_cyc);
    txn_t li[$];
    txn_t ld[$];
    txn_t t;
    exp_t e;
    int   starve;
    int   n;
    bit   pick_d;
    bit   oor;
    li = iq;
    ld = dq;
    starve = 0;
    n = 0;
    while (li.size() > 0 || ld.size() > 0) begin
      pick_d = (ld.size() > 0) && !(li.size() > 0 && starve == int'(MAX_WAIT));
      if (pick_d) begin
        t = ld.pop_front();
        starve = (li.size() > 0) ? ((starve < int'(MAX_WAIT)) ? starve + 1 : starve) : 0;
      end else begin
        t = li.pop_front();
        starve = 0;
      end
      oor      = (t.addr >= LIMIT);
      e.port_d = pick_d;
      e.err    = oor;
      e.maddr  = oor ? 32'h0 : t.addr;
      e.mwdata = (!oor && t.we) ? t.wdata : 32'h0;
      e.strobe = oor ? 2'b00 : (t.we ? 2'b01 : 2'b10);
      e.cyc    = start_cyc + 2 + 3 * n;
      if (t.we) begin
        if (!oor) ref_mem[t.addr[7:2]] = t.wdata;
        e.rdata = last_d;
      end else begin
        e.rdata = oor ? 32'h0 : ref_mem[t.addr[7:2]];
        if (pick_d) last_d = e.rdata;
        else        last_i = e.rdata;
      end
      sb.push_back(e);
      n++;
    end
  endfunction

  task automatic drive_i();
    txn_t t;
    int   guard;
    while (iq.size() > 0) begin
      t = iq.pop_front();
      i_req  = 1'b1;
      i_addr = t.addr;
      guard  = 0;
      do begin @(negedge clk); guard++; end while (!i_ack && guard < 100);
      if (!i_ack) begin
        timeout_fail("i_ack wait");
        iq.delete();
      end
    end
    i_req  = 1'b0;
    i_addr = 32'h0;
  endtask

  task automatic drive_d();
    txn_t t;
    int   guard;
    while (dq.size() > 0) begin
      t = dq.pop_front();
      d_req   = 1'b1;
      d_we    = t.we;
      d_addr  = t.addr;
      d_wdata = t.wdata;
      guard   = 0;
      do begin @(negedge clk); guard++; end while (!d_ack && guard < 100);
      if (!d_ack) begin
        timeout_fail("d_ack wait");
        dq.delete();
      end
    end
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  task automatic run_batch();
    @(negedge clk);
    predict(cyc);
    fork
      drive_i();
      drive_d();
    join
    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic reset_mid_access();
    int guard;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hCAFE_F00D;
    guard   = 0;
    do begin @(negedge clk); guard++; end while (!MemWrite && guard < 10);
    check("store reaches ACCESS", 32'(MemWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    check("strobes drop on reset", 32'({MemRead, MemWrite}), 32'h0);
    check("address cleared on reset", MemAddress, 32'h0);
    check("busy cleared on reset", 32'(busy), 32'h0);
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    @(negedge clk);
    check("no ack during reset", 32'({i_ack, d_ack}), 32'h0);
    check("d_rdata after reset", d_rdata, 32'h0);
    check("i_rdata after reset", i_rdata, 32'h0);
    rst_n  = 1'b1;
    last_i = 32'h0;
    last_d = 32'h0;
  endtask

  // Monitor: scoreboard compare on every ack plus bus sanity every cycle.
  logic        p_rd;
  logic        p_wr;
  logic        p_busy;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_ack || d_ack) begin
        check("single ack", 32'(i_ack & d_ack), 32'h0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ack: i_ack=%b d_ack=%b with empty scoreboard (cycle %0d)",
                   i_ack, d_ack, cyc);
        end else begin
          m_e = sb.pop_front();
          check("ack port", 32'(d_ack), 32'(m_e.port_d));
          check("ack rdata", d_ack ? d_rdata : i_rdata, m_e.rdata);
          check("ack err", 32'(err), 32'(m_e.err));
          check("ack cycle", 32'(cyc), 32'(m_e.cyc));
          check("busy in access", 32'(p_busy), 32'h1);
          check("access strobes", 32'({p_rd, p_wr}), 32'(m_e.strobe));
          check("access address", p_addr, m_e.maddr);
          check("access wdata", p_wdata, m_e.mwdata);
        end
      end
      if (err) check("err only with ack", 32'(i_ack | d_ack), 32'h1);
      if (MemRead || MemWrite) check("strobes exclusive", 32'(MemRead & MemWrite), 32'h0);
      if (!(busy && !i_ack && !d_ack))
        check("bus quiet outside access",
              MemAddress | WriteData | 32'({MemRead, MemWrite}), 32'h0);
    end
    p_rd    = MemRead;
    p_wr    = MemWrite;
    p_busy  = busy;
    p_addr  = MemAddress;
    p_wdata = WriteData;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  int ni;
  int nd;

  initial begin
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    last_i  = 32'h0;
    last_d  = 32'h0;
    for (int k = 0; k < 64; k++) ref_mem[k] = 32'h0;

    #12;
    check("reset i_ack", 32'(i_ack), 32'h0);
    check("reset d_ack", 32'(d_ack), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset MemRead", 32'(MemRead), 32'h0);
    check("reset MemWrite", 32'(MemWrite), 32'h0);
    check("reset MemAddress", MemAddress, 32'h0);
    check("reset WriteData", WriteData, 32'h0);
    check("reset i_rdata", i_rdata, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load back
    dq.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
    run_batch();
    dq.push_back(mk(1'b0, 32'h10, 32'h0));
    run_batch();

    // Simultaneous requests: D first, I three cycles later
    iq.push_back(mk(1'b0, 32'h10, 32'h0));
    dq.push_back(mk(1'b0, 32'h14, 32'h0));
    run_batch();

    // Starvation guard: fetch gets through after every MAX_WAIT loads/stores
    for (int k = 0; k < 3; k++) iq.push_back(mk(1'b0, 32'($urandom_range(0, 255)), 32'h0));
    for (int k = 0; k < 12; k++)
      dq.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom()));
    run_batch();

    // Out-of-range accesses, including the exact limit
    dq.push_back(mk(1'b1, 32'h100, 32'h1234_5678));
    dq.push_back(mk(1'b0, 32'h100, 32'h0));
    iq.push_back(mk(1'b0, 32'h1FC, 32'h0));
    dq.push_back(mk(1'b0, 32'hFC, 32'h0));
    run_batch();

    // Reset during a store's ACCESS: old value must survive
    dq.push_back(mk(1'b1, 32'h20, 32'h1234_5678));
    run_batch();
    reset_mid_access();
    dq.push_back(mk(1'b0, 32'h20, 32'h0));
    run_batch();

    // Randomized mixes
    repeat (30) begin
      ni = $urandom_range(0, 4);
      nd = $urandom_range(0, 8);
      if (ni + nd == 0) nd = 1;
      for (int k = 0; k < ni; k++) iq.push_back(mk(1'b0, rand_addr(), 32'h0));
      for (int k = 0; k < nd; k++)
        dq.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom()));
      run_batch();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port 64-word data memory and shares it between two requesters: instruction fetch (I port, read-only) and load/store unit (D port, read/write).
- Sits between the core's fetch/LSU stages and the memory block. It owns MemRead, MemWrite, MemAddress and WriteData, and registers ReadData back to the winning requester.
- Each access is a 3-state transaction with a req/ack handshake.
- Fixed D-over-I priority, with a starvation guard for the I port.

Parameters:
- MAX_WAIT, 4: consecutive D grants tolerated while i_req is pending; the next grant is forced to I. Legal range 1..15.
- ADDR_LIMIT, 32'h100: first byte address outside the memory. Accesses at or above it are rejected.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  load/store request; held with d_we, d_addr, d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  load/store byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: load/store complete, d_rdata valid for loads
- d_rdata  out  32  loaded word
- err  out  1  qualifies the ack in the same cycle: access was out of range
- busy  out  1  high in ACCESS and RESP
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemAddress  out  32  memory address
- WriteData  out  32  memory write data
- ReadData  in  32  memory combinational read data

Behaviour:
- Reset (async, rst_n low): state=IDLE; owner=I; starvation count=0. Outputs all 0: i_ack, d_ack, err, busy, MemRead, MemWrite, MemAddress, WriteData, i_rdata, d_rdata.
- States: IDLE, ACCESS, RESP. Requests are sampled only in IDLE.
- IDLE → ACCESS on any req. At that edge the block latches owner, addr, we and wdata.
- Winner selection:
  - D wins if d_req=1, unless i_req=1 and count==MAX_WAIT; then I wins.
  - I wins if only i_req=1.
- Starvation count:
  - Increments on each D grant while i_req=1, saturating at MAX_WAIT.
  - Clears on an I grant, or in any IDLE cycle with i_req=0.
- Range check: addr >= ADDR_LIMIT sets the latched range_err flag.
- ACCESS (exactly 1 cycle):
  - If range_err=0: MemAddress=latched addr. MemRead=!we. MemWrite=we. WriteData=latched wdata when we=1, else 0.
  - If range_err=1: both strobes stay 0 and MemAddress=0.
  - On the exiting edge, ReadData is captured into the owner's rdata register when it is a read. Captures 0 when range_err=1.
  - Always → RESP.
- RESP (exactly 1 cycle): owner's ack=1; err=range_err; rdata stable. → IDLE.
- Outside ACCESS: MemRead=MemWrite=0 and MemAddress=WriteData=0. MemRead and MemWrite are never high together.
- Latency: req sampled at edge k → ACCESS in cycle k..k+1 → ack high in cycle k+1..k+2. Throughput is 1 transaction per 3 cycles when requests are back-to-back.
- rdata registers hold their value until the next read by the same port. Writes leave d_rdata unchanged.
- A requester must keep req high until its ack. A req still high in the IDLE cycle after the ack is a new request.
- The I port never writes. There is no write path from I.
- Misaligned addresses (addr[1:0]≠0) are passed through unchanged; the memory word-indexes on addr[7:2]. No error is raised.
- Reset mid-transaction: if rst_n falls during ACCESS, strobes drop immediately, no ack is issued, and the requester must re-request. A write is not committed if rst_n is low at the ACCESS exit edge.

Test Plan:
- Reset then d_req store, d_addr=0x10, d_wdata=0xDEADBEEF → MemWrite=1 for 1 cycle with MemAddress=0x10; d_ack 2 cycles after the sample edge; err=0.
- d_req load at 0x10 → MemRead 1 cycle; d_ack with d_rdata=0xDEADBEEF.
- i_req at 0x10 and d_req load at 0x14, same cycle → D served first; I served next (i_ack 3 cycles after d_ack), i_rdata=0xDEADBEEF.
- i_req held high, d_req continuously high, MAX_WAIT=4 → exactly 4 D grants, then 1 I grant, then D resumes; count returns to 0.
- d_req store at 0x100 → no MemWrite; d_ack with err=1. A following load at 0x100 returns d_rdata=0, err=1.
- Store at 0x20 with rst_n pulsed low during ACCESS → no d_ack. After reset, a load at 0x20 returns the value previously stored there (no write committed).
